// File: rtl/axi_memory_responder.sv
// AXI3-subset memory responder: independent write (AW/W/B) and read (AR/R) engines
// over an on-chip word array, with a fixed idle gap before the first read beat.
module axi_memory_responder #(
  parameter int unsigned ADDR_WIDTH   = 26,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH_LOG2   = 16,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [3:0]            AWID,
  input  logic [3:0]            AWLEN,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  WVALID,
  output logic                  WREADY,
  input  logic                  WLAST,
  input  logic [3:0]            WID,
  input  logic [DATA_WIDTH-1:0] WDATA,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic [3:0]            BID,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  input  logic [3:0]            ARID,
  input  logic [3:0]            ARLEN,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic                  RLAST,
  output logic [3:0]            RID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  proto_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] idx_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  w_state_e        w_state_q, w_state_d;
  logic            awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [3:0]      bid_q, bid_d, wlen_q, wlen_d;
  idx_t            widx_q, widx_d;
  logic [4:0]      wbeat_q, wbeat_d;    // saturates at 16 so overlong bursts stay detectable
  logic            perr_q, perr_d;
  logic            mem_we;
  idx_t            mem_waddr;

  r_state_e        r_state_q, r_state_d;
  logic            arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [3:0]      rid_q, rid_d, rlen_q, rlen_d, rbeat_q, rbeat_d, rcnt_q, rcnt_d;
  idx_t            ridx_q, ridx_d, rd_addr;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rd_word;

  logic unused_bits;
  assign unused_bits = ^{WID, AWADDR, ARADDR};

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    widx_d    = widx_q;
    wlen_d    = wlen_q;
    wbeat_d   = wbeat_q;
    perr_d    = perr_q;
    mem_we    = 1'b0;
    mem_waddr = widx_q + idx_t'(wbeat_q[3:0]);
    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (AWVALID && awready_q) begin
          bid_d     = AWID;
          widx_d    = AWADDR[DEPTH_LOG2+1:2];
          wlen_d    = AWLEN;
          wbeat_d   = '0;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (WVALID && wready_q) begin
          if (wbeat_q <= {1'b0, wlen_q}) mem_we = 1'b1;
          else                           perr_d = 1'b1;
          if (WLAST && (wbeat_q != {1'b0, wlen_q})) perr_d = 1'b1;
          if (wbeat_q != 5'd16) wbeat_d = wbeat_q + 5'd1;
          if (WLAST) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (BREADY && bvalid_q) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Address of the word the read side will present next cycle; a same-edge write is forwarded.
  always_comb begin
    case (r_state_q)
      R_IDLE:  rd_addr = ARADDR[DEPTH_LOG2+1:2];
      R_WAIT:  rd_addr = ridx_q;
      default: rd_addr = ridx_q + idx_t'(rbeat_q) + idx_t'(1);
    endcase
    rd_word = (mem_we && (mem_waddr == rd_addr)) ? WDATA : mem[rd_addr];
  end

  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rlen_d    = rlen_q;
    rbeat_d   = rbeat_q;
    rcnt_d    = rcnt_q;
    ridx_d    = ridx_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ARVALID && arready_q) begin
          rid_d     = ARID;
          ridx_d    = ARADDR[DEPTH_LOG2+1:2];
          rlen_d    = ARLEN;
          rbeat_d   = '0;
          arready_d = 1'b0;
          if (READ_LATENCY == 0) begin
            r_state_d = R_BURST;
            rvalid_d  = 1'b1;
            rdata_d   = rd_word;
            rlast_d   = (ARLEN == 4'd0);
          end else begin
            r_state_d = R_WAIT;
            rcnt_d    = 4'(READ_LATENCY);
          end
        end
      end
      R_WAIT: begin
        rcnt_d = rcnt_q - 4'd1;
        if (rcnt_q == 4'd1) begin
          r_state_d = R_BURST;
          rvalid_d  = 1'b1;
          rdata_d   = rd_word;
          rlast_d   = (rlen_q == 4'd0);
        end
      end
      R_BURST: begin
        if (RREADY) begin
          if (rlast_q) begin
            r_state_d = R_IDLE;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
          end else begin
            rbeat_d = rbeat_q + 4'd1;
            rdata_d = rd_word;
            rlast_d = ((rbeat_q + 4'd1) == rlen_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // NOTE: the array has no reset; contents survive rst_n and only control state is cleared.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= WDATA;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      widx_q    <= '0;
      wlen_q    <= '0;
      wbeat_q   <= '0;
      perr_q    <= 1'b0;
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rlen_q    <= '0;
      rbeat_q   <= '0;
      rcnt_q    <= '0;
      ridx_q    <= '0;
      rdata_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      widx_q    <= widx_d;
      wlen_q    <= wlen_d;
      wbeat_q   <= wbeat_d;
      perr_q    <= perr_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rlen_q    <= rlen_d;
      rbeat_q   <= rbeat_d;
      rcnt_q    <= rcnt_d;
      ridx_q    <= ridx_d;
      rdata_q   <= rdata_d;
    end
  end

  assign AWREADY   = awready_q;
  assign WREADY    = wready_q;
  assign BVALID    = bvalid_q;
  assign BID       = bid_q;
  assign ARREADY   = arready_q;
  assign RVALID    = rvalid_q;
  assign RLAST     = rlast_q;
  assign RID       = rid_q;
  assign RDATA     = rdata_q;
  assign proto_err = perr_q;

endmodule
